// File: rtl/spart_rx_framer.sv
// spart_rx_framer: 8N1 serial receiver that groups every three accepted bytes
// into one 24-bit message. Byte 0 lands in rx_data[7:0], byte 2 in [23:16].
// A partial message that sits idle for TIMEOUT_BITS bit times is thrown away.
//
// Handshake: there is no flow control. interrupt_board, frame_err and
// timeout_err are single-cycle strobes, never more than one per cycle.
// rx_data is valid from the interrupt_board cycle until the next one.
module spart_rx_framer #(
  parameter int BAUD_DIV     = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [23:0] rx_data,
  output logic        interrupt_board,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int TO_W   = $clog2(TIMEOUT_BITS * BAUD_DIV);

  localparam logic [BAUD_W-1:0] HALF_PT = BAUD_W'(BAUD_DIV / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_PT = BAUD_W'(BAUD_DIV - 1);
  localparam logic [TO_W-1:0]   TO_PT   = TO_W'(TIMEOUT_BITS * BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Line synchronizer and edge-detect state
  logic              meta_q, meta_d;
  logic              rxd_s_q, rxd_s_d;
  logic              rxd_prev_q, rxd_prev_d;
  logic [1:0]        sync_vld_q, sync_vld_d;
  logic              seen_high_q, seen_high_d;
  logic              fall;

  // Receiver FSM and datapath state
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [7:0]        byte1_q, byte1_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [23:0]       rx_data_q, rx_data_d;
  logic              irq_q, irq_d;
  logic              ferr_q, ferr_d;
  logic              terr_q, terr_d;

  // Synchronizer pipeline; sync_vld marks when rxd_s carries a real line
  // sample (not the reset value), so start detection only arms after a
  // genuine high has been seen following reset.
  always_comb begin
    meta_d      = rxd;
    rxd_s_d     = meta_q;
    rxd_prev_d  = rxd_s_q;
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    seen_high_d = seen_high_q | (sync_vld_q[1] & rxd_s_q);
    fall        = seen_high_q & rxd_prev_q & ~rxd_s_q;
  end

  // Next-state, bit sampling, message assembly and inter-byte timeout
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    to_d       = to_q;
    rx_data_d  = rx_data_q;
    irq_d      = 1'b0;
    ferr_d     = 1'b0;
    terr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Timeout is evaluated first so a start edge on the terminal cycle
        // still discards the old partial message and begins a fresh one.
        if (byte_cnt_q != 2'd0) begin
          if (to_q == TO_PT) begin
            terr_d     = 1'b1;
            byte_cnt_d = 2'd0;
            to_d       = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        if (fall) begin
          state_d = START;
          baud_d  = '0;
          to_d    = '0;
        end
      end

      START: begin
        if (baud_q == HALF_PT) begin
          baud_d = '0;
          bit_d  = 3'd0;
          // A line back high at mid start bit is a glitch: drop it quietly.
          state_d = rxd_s_q ? IDLE : DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_q == FULL_PT) begin
          baud_d  = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_q == FULL_PT) begin
          baud_d = '0;
          if (rxd_s_q) begin
            state_d = IDLE;
            to_d    = '0;
            unique case (byte_cnt_q)
              2'd0: begin
                byte0_d    = shift_q;
                byte_cnt_d = 2'd1;
              end
              2'd1: begin
                byte1_d    = shift_q;
                byte_cnt_d = 2'd2;
              end
              default: begin
                rx_data_d  = {shift_q, byte1_q, byte0_q};
                irq_d      = 1'b1;
                byte_cnt_d = 2'd0;
              end
            endcase
          end else begin
            ferr_d     = 1'b1;
            byte_cnt_d = 2'd0;
            state_d    = BREAK;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      BREAK: begin
        // Line held low after a bad stop bit: wait for idle before rearming.
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      meta_q      <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_prev_q  <= 1'b1;
      sync_vld_q  <= 2'b00;
      seen_high_q <= 1'b0;
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      byte_cnt_q  <= 2'd0;
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
      to_q        <= '0;
      rx_data_q   <= 24'h000000;
      irq_q       <= 1'b0;
      ferr_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      rxd_s_q     <= rxd_s_d;
      rxd_prev_q  <= rxd_prev_d;
      sync_vld_q  <= sync_vld_d;
      seen_high_q <= seen_high_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      to_q        <= to_d;
      rx_data_q   <= rx_data_d;
      irq_q       <= irq_d;
      ferr_q      <= ferr_d;
      terr_q      <= terr_d;
    end
  end

  assign rx_data         = rx_data_q;
  assign interrupt_board = irq_q;
  assign frame_err       = ferr_q;
  assign timeout_err     = terr_q;
  assign busy            = (state_q != IDLE) || (byte_cnt_q != 2'd0);

endmodule

// File: tb/tb_spart_rx_framer.sv
// Bench for spart_rx_framer at BAUD_DIV=16, TIMEOUT_BITS=20.
// Line changes are driven 1 time unit after a rising edge; the DUT then needs
// 3 edges to enter START, 8 more for the half bit, and 16 per data/stop bit,
// so a pulse is visible 3 + 8 + 9*16 = 155 cycles after the start bit is driven.
module tb_spart_rx_framer;

  localparam int BAUD = 16;
  localparam int TOB  = 20;
  localparam int LAT  = 155;
  localparam int TO_LAT = LAT + TOB * BAUD;

  localparam logic [1:0] K_IRQ = 2'd1;
  localparam logic [1:0] K_FE  = 2'd2;
  localparam logic [1:0] K_TO  = 2'd3;

  logic        sys_clk;
  logic        rst;
  logic        rxd;
  logic [23:0] rx_data;
  logic        interrupt_board;
  logic        frame_err;
  logic        timeout_err;
  logic        busy;

  int checks;
  int errors;
  int cyc;

  logic [25:0] exp_q[$];
  int          exp_t_q[$];
  logic [23:0] last_msg;

  logic [25:0] mon_e;
  int          mon_t;
  logic [1:0]  mon_k;

  spart_rx_framer #(
    .BAUD_DIV     (BAUD),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .rxd             (rxd),
    .rx_data         (rx_data),
    .interrupt_board (interrupt_board),
    .frame_err       (frame_err),
    .timeout_err     (timeout_err),
    .busy            (busy)
  );

  // Clock and cycle counter
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [1:0] k, input logic [23:0] d, input int t);
    exp_q.push_back({k, d});
    exp_t_q.push_back(t);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_cycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(BAUD);
    end
    rxd = stop_bit;
    wait_cycles(BAUD);
  endtask

  // Scoreboard monitor: every strobe pops one expectation (kind, rx_data, cycle)
  always @(negedge sys_clk) begin
    if (!rst && (interrupt_board || frame_err || timeout_err)) begin
      chk("single_pulse", 32'(interrupt_board) + 32'(frame_err) + 32'(timeout_err), 32'd1);
      mon_k = interrupt_board ? K_IRQ : (frame_err ? K_FE : K_TO);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse kind=%0d rx_data=%06h at cycle %0d", mon_k, rx_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        chk("pulse_kind", 32'(mon_k), 32'(mon_e[25:24]));
        chk("rx_data", 32'(rx_data), 32'(mon_e[23:0]));
        chk("pulse_cycle", 32'(cyc), 32'(mon_t));
      end
    end
  end

  initial begin
    int t0;
    checks   = 0;
    errors   = 0;
    last_msg = 24'h000000;
    rst      = 1'b1;
    rxd      = 1'b1;

    // Reset values
    wait_cycles(3);
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_irq", 32'(interrupt_board), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_cycles(10);

    // Scenario 1: back-to-back message
    send_byte(8'h5A, 1'b1);
    chk("busy_after_byte0", 32'(busy), 32'd1);
    send_byte(8'hC3, 1'b1);
    last_msg = 24'h01C35A;
    expect_pulse(K_IRQ, last_msg, cyc + LAT);
    send_byte(8'h01, 1'b1);
    chk("busy_after_msg", 32'(busy), 32'd0);
    wait_cycles(20);

    // Scenario 2: short glitch between bytes does not disturb the byte count
    send_byte(8'h10, 1'b1);
    wait_cycles(16);
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(40);
    chk("busy_after_glitch", 32'(busy), 32'd1);
    send_byte(8'h20, 1'b1);
    last_msg = 24'h302010;
    expect_pulse(K_IRQ, last_msg, cyc + LAT);
    send_byte(8'h30, 1'b1);
    wait_cycles(20);

    // Scenario 3: bad stop bit, line held low, then a clean message
    send_byte(8'h11, 1'b1);
    expect_pulse(K_FE, last_msg, cyc + LAT);
    send_byte(8'h22, 1'b0);
    wait_cycles(50);
    chk("busy_in_break", 32'(busy), 32'd1);
    rxd = 1'b1;
    wait_cycles(32);
    chk("busy_after_break", 32'(busy), 32'd0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    last_msg = 24'hCCBBAA;
    expect_pulse(K_IRQ, last_msg, cyc + LAT);
    send_byte(8'hCC, 1'b1);
    wait_cycles(20);

    // Scenario 4: inter-byte timeout at the exact terminal count
    expect_pulse(K_TO, last_msg, cyc + TO_LAT);
    send_byte(8'h11, 1'b1);
    wait_cycles(320);
    chk("busy_after_timeout", 32'(busy), 32'd0);
    send_byte(8'h03, 1'b1);
    send_byte(8'h02, 1'b1);
    last_msg = 24'h010203;
    expect_pulse(K_IRQ, last_msg, cyc + LAT);
    send_byte(8'h01, 1'b1);
    wait_cycles(20);

    // Scenario 6: start edge lands on the timeout terminal cycle
    t0 = cyc;
    expect_pulse(K_TO, last_msg, t0 + TO_LAT);
    send_byte(8'h11, 1'b1);
    wait_cycles(TO_LAT - 3 - 10 * BAUD);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    last_msg = 24'h665544;
    expect_pulse(K_IRQ, last_msg, cyc + LAT);
    send_byte(8'h66, 1'b1);
    wait_cycles(20);

    // Scenario 5: reset during byte 1, after bit 4
    send_byte(8'h77, 1'b1);
    rxd = 1'b0;
    wait_cycles(BAUD);
    for (int i = 0; i < 5; i++) begin
      rxd = ~i[0];
      wait_cycles(BAUD);
    end
    rst = 1'b1;
    rxd = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    last_msg = 24'h000000;
    chk("midreset_rx_data", 32'(rx_data), 32'h0);
    chk("midreset_irq", 32'(interrupt_board), 32'd0);
    chk("midreset_frame_err", 32'(frame_err), 32'd0);
    chk("midreset_timeout_err", 32'(timeout_err), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    wait_cycles(40);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    last_msg = 24'hC3B2A1;
    expect_pulse(K_IRQ, last_msg, cyc + LAT);
    send_byte(8'hC3, 1'b1);
    wait_cycles(50);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_rx_framer.md
SPART_RX_FRAMER -- requirements
Module: spart_rx_framer

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 434, giving sys_clk cycles per serial bit time (minimum 8).
REQ-002 The block SHALL have parameter TIMEOUT_BITS, default 20, giving the inter-byte timeout in bit times.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. The ports are sys_clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-004 The block SHALL have port rxd (input, 1): asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port rx_data (output, 24): last complete 3-byte message.
REQ-006 The block SHALL have port interrupt_board (output, 1): one-cycle pulse when rx_data is updated.
REQ-007 The block SHALL have port frame_err (output, 1): one-cycle pulse on a bad stop bit.
REQ-008 The block SHALL have port timeout_err (output, 1): one-cycle pulse when a partial message is discarded by timeout.
REQ-009 The block SHALL have port busy (output, 1): high whenever the state is not IDLE, or 1 or 2 bytes of a message are held.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rxd_s).
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-012 In IDLE, a falling edge of rxd_s (previous sample 1, current 0) SHALL move to START and clear the baud counter.
REQ-013 In START, at count BAUD_DIV/2-1 (integer division), the block SHALL sample rxd_s: if 0, go to DATA; if 1, treat it as a glitch and return to IDLE with no error pulse.
REQ-014 In DATA, the block SHALL sample 8 bits, each BAUD_DIV cycles after the previous sample point, and shift them LSB first.
REQ-015 In STOP, the block SHALL sample BAUD_DIV cycles after the last data bit.
REQ-016 On a STOP sample of 1, the byte SHALL be accepted and the FSM SHALL return to IDLE in the same cycle.
REQ-017 On a STOP sample of 0, frame_err SHALL pulse, the partial message SHALL be discarded (byte count = 0), and the FSM SHALL go to BREAK.
REQ-018 BREAK SHALL wait until rxd_s = 1, then go to IDLE; no start detection SHALL occur in BREAK.
REQ-019 Accepted bytes SHALL be placed by arrival order: byte 0 into rx_data[7:0], byte 1 into [15:8], byte 2 into [23:16].
REQ-020 rx_data SHALL update only when byte 2 is accepted; the update SHALL occur in the same cycle as the interrupt_board pulse, and the byte count SHALL wrap to 0 in that cycle.
REQ-021 rx_data SHALL hold its value until the next complete message; no partial message SHALL ever be visible on rx_data.
REQ-022 The timeout counter SHALL run only in IDLE with byte count 1 or 2, and SHALL clear on each accepted byte and on entry to START.
REQ-023 When the timeout counter reaches TIMEOUT_BITS*BAUD_DIV-1 in IDLE, timeout_err SHALL pulse and byte count SHALL clear.
REQ-024 If a falling edge occurs in the same cycle as the timeout terminal count, the timeout SHALL take effect (partial message discarded) and the new byte SHALL still be received as byte 0.
REQ-025 At most one of interrupt_board, frame_err, or timeout_err SHALL pulse in any cycle.
REQ-026 Latency SHALL be fixed at 2 synchronizer cycles plus the stop-bit sample point to the interrupt_board pulse.
REQ-027 Counter widths SHALL be sized with clog2 of their terminal counts, and no counter SHALL wrap silently.

Reset
REQ-028 While rst = 1, the block SHALL enter state IDLE; the synchronizer flops and previous sample SHALL be set to 1; all counters and the byte count SHALL be set to 0; rx_data SHALL be 24'h000000; interrupt_board, frame_err, timeout_err, and busy SHALL be 0.
REQ-029 A reset asserted mid-byte or mid-message SHALL discard all partial data, with no error pulse.
REQ-030 After reset release, the block SHALL not detect a start until rxd_s has been sampled high at least once.

Verification (BAUD_DIV=16, TIMEOUT_BITS=20)
REQ-031 Scenario 1: send bytes 0x5A, 0xC3, 0x01 back-to-back -> exactly one interrupt_board pulse, with rx_data = 24'h01C35A in that cycle; busy is 0 afterwards.
REQ-032 Scenario 2: rxd low pulse of 4 cycles while IDLE -> return to IDLE, no pulses, byte count unchanged.
REQ-033 Scenario 3: send 0x11, then 0x22 with stop bit = 0, held low 50 cycles, then send 0xAA, 0xBB, 0xCC -> one frame_err pulse, no start detected during the low period, then rx_data = 24'hCCBBAA with interrupt_board.
REQ-034 Scenario 4: send 0x11, idle 320 cycles -> timeout_err pulses exactly at the terminal count; the following 3-byte message 0x03, 0x02, 0x01 gives rx_data = 24'h010203.
REQ-035 Scenario 5: assert rst for 1 cycle after bit 4 of byte 1 -> all outputs at reset values; the next clean 3-byte message is assembled from byte 0.
REQ-036 Scenario 6: start edge coincident with the timeout terminal count -> timeout_err pulses, and the byte is stored as byte 0 of a new message.
